// File: rtl/and_bitwise.sv
// rtl/and_bitwise.sv - purely combinational WIDTH-bit bitwise AND
module and_bitwise #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
);

  // Zero-latency AND, independent of any clock or reset
  assign out = a & b;

endmodule

// File: rtl/student_and_gate.sv
// rtl/student_and_gate.sv - bitwise AND with registered copy and saturating activity counter
module student_and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [CNT_W-1:0] hi_cnt
);

  // Counter stops here rather than wrapping back to zero
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] out_d;
  logic [CNT_W-1:0] hi_cnt_q;
  logic [CNT_W-1:0] hi_cnt_d;

  and_bitwise #(
    .WIDTH (WIDTH)
  ) u_and (
    .a   (a),
    .b   (b),
    .out (out)
  );

  // Next state: capture the AND result, count cycles with any result bit high
  always_comb begin
    out_d    = out;
    hi_cnt_d = hi_cnt_q;
    if ((|out) && (hi_cnt_q != CNT_MAX)) begin
      hi_cnt_d = hi_cnt_q + CNT_ONE;
    end
  end

  // State registers; reset clears them immediately without a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      hi_cnt_q <= '0;
    end else begin
      out_q    <= out_d;
      hi_cnt_q <= hi_cnt_d;
    end
  end

  assign hi_cnt = hi_cnt_q;

endmodule

// File: tb/tb_student_and_gate.sv
// tb/tb_student_and_gate.sv - randomized self-checking bench against a behavioural model
module tb_student_and_gate;

  logic clk;
  logic clk_run;

  // Three instances: default config, narrow counter, 4-bit datapath
  logic       rst1, rst3, rst4;
  logic       a1, b1, out1, q1;
  logic       a3, b3, out3, q3;
  logic [3:0] a4, b4, out4, q4;
  logic [15:0] cnt1;
  logic [2:0]  cnt3;
  logic [15:0] cnt4;

  // Behavioural model state
  int         m_cnt1, m_cnt3, m_cnt4;
  logic       m_q1, m_q3;
  logic [3:0] m_q4;

  int vectors;
  int miscompares;

  student_and_gate #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .out(out1), .out_q(q1), .hi_cnt(cnt1)
  );

  student_and_gate #(.WIDTH(1), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst3), .a(a3), .b(b3), .out(out3), .out_q(q3), .hi_cnt(cnt3)
  );

  student_and_gate #(.WIDTH(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst4), .a(a4), .b(b4), .out(out4), .out_q(q4), .hi_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = clk_run ? ~clk : clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, need finish)");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Saturating count rule: add one when any result bit is set, cap at max
  function automatic int next_cnt(input int cnt, input bit any_hi, input int max);
    int n;
    n = cnt + (any_hi ? 1 : 0);
    return (n > max) ? max : n;
  endfunction

  // One clock edge, with the model advanced from the pre-edge inputs
  task automatic tick();
    int         n1, n3, n4;
    logic       nq1, nq3;
    logic [3:0] nq4;
    nq1 = rst1 ? 1'b0 : (a1 & b1);
    nq3 = rst3 ? 1'b0 : (a3 & b3);
    nq4 = rst4 ? 4'h0 : (a4 & b4);
    n1  = rst1 ? 0 : next_cnt(m_cnt1, (a1 & b1) != 0, 65535);
    n3  = rst3 ? 0 : next_cnt(m_cnt3, (a3 & b3) != 0, 7);
    n4  = rst4 ? 0 : next_cnt(m_cnt4, (a4 & b4) != 4'h0, 65535);
    @(posedge clk);
    #1;
    m_q1 = nq1; m_q3 = nq3; m_q4 = nq4;
    m_cnt1 = n1; m_cnt3 = n3; m_cnt4 = n4;
  endtask

  task automatic check_all_regs(input string tag);
    check_eq({tag, "_q1"},   16'(q1),   16'(m_q1));
    check_eq({tag, "_cnt1"}, cnt1,      16'(m_cnt1));
    check_eq({tag, "_q3"},   16'(q3),   16'(m_q3));
    check_eq({tag, "_cnt3"}, 16'(cnt3), 16'(m_cnt3));
    check_eq({tag, "_q4"},   16'(q4),   16'(m_q4));
    check_eq({tag, "_cnt4"}, cnt4,      16'(m_cnt4));
  endtask

  initial begin
    logic [1:0] tt [4];
    vectors = 0;
    miscompares = 0;
    clk_run = 1'b0;
    rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    a1 = 1'b0; b1 = 1'b0; a3 = 1'b0; b3 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    m_q1 = 1'b0; m_q3 = 1'b0; m_q4 = 4'h0;
    m_cnt1 = 0; m_cnt3 = 0; m_cnt4 = 0;
    #1;

    // Reset state
    check_eq("reset_q1",   16'(q1), 16'h0);
    check_eq("reset_cnt1", cnt1,    16'h0);
    check_eq("reset_cnt3", 16'(cnt3), 16'h0);
    check_eq("reset_q4",   16'(q4), 16'h0);

    // Truth table with the clock idle
    tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b10; tt[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      a1 = tt[i][1];
      b1 = tt[i][0];
      #1;
      check_eq($sformatf("truth_%0d%0d", a1, b1), 16'(out1), 16'(a1 && b1));
    end

    // Output is live during reset while registers stay clear
    a1 = 1'b1; b1 = 1'b1;
    #1;
    check_eq("rst_out1", 16'(out1), 16'h1);
    check_eq("rst_q1",   16'(q1),   16'h0);
    check_eq("rst_cnt1", cnt1,      16'h0);

    rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
    a3 = 1'b1; b3 = 1'b1;
    clk_run = 1'b1;

    // Registered path on the default instance, saturation on the narrow one
    tick();
    check_eq("reg_edge1_q1", 16'(q1), 16'h1);
    a1 = 1'b1; b1 = 1'b0;
    tick();
    check_eq("reg_edge2_q1",   16'(q1), 16'h0);
    check_eq("reg_edge2_cnt1", cnt1,    16'h1);
    for (int i = 3; i <= 10; i++) begin
      tick();
      check_eq($sformatf("sat_cnt3_e%0d", i), 16'(cnt3), 16'((i > 7) ? 7 : i));
    end
    check_all_regs("sat");

    // Count to 5 then reset asynchronously between edges
    #2; rst3 = 1'b1; #1; rst3 = 1'b0;
    m_cnt3 = 0; m_q3 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("pre_areset_cnt3", 16'(cnt3), 16'h5);
    #2;
    rst3 = 1'b1;
    #1;
    check_eq("areset_cnt3", 16'(cnt3), 16'h0);
    check_eq("areset_q3",   16'(q3),   16'h0);
    m_cnt3 = 0; m_q3 = 1'b0;
    #1;
    rst3 = 1'b0;
    tick();
    check_eq("resume_cnt3", 16'(cnt3), 16'h1);
    check_eq("resume_q3",   16'(q3),   16'h1);

    // 4-bit directed vectors
    a4 = 4'b1100; b4 = 4'b1010;
    #1;
    check_eq("w4_out_a", 16'(out4), 16'h8);
    tick();
    check_eq("w4_cnt_a", cnt4, 16'h1);
    check_eq("w4_q_a", 16'(q4), 16'h8);
    a4 = 4'b0101; b4 = 4'b1010;
    #1;
    check_eq("w4_out_b", 16'(out4), 16'h0);
    tick();
    check_eq("w4_cnt_b", cnt4, 16'h1);
    check_all_regs("dir");

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 300; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom);
      a3 = 1'($urandom); b3 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom);
      #1;
      check_eq("rnd_out1", 16'(out1), 16'(a1 & b1));
      check_eq("rnd_out4", 16'(out4), 16'(a4 & b4));
      if ($urandom_range(19) == 0) begin
        rst4 = 1'b1;
        #1;
        check_eq("rnd_areset_cnt4", cnt4, 16'h0);
        m_cnt4 = 0; m_q4 = 4'h0;
        rst4 = 1'b0;
      end
      tick();
      check_all_regs("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
